// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared register map, FSM encoding and STATUS layout for the UART MMIO front end.
package uart_mmio_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int STAT_ERR = 2;
    localparam int STAT_TXF = 1;
    localparam int STAT_RXE = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic [7:0] status_byte(input logic err, input logic txf, input logic rxe);
        logic [7:0] s;
        s           = '0;
        s[STAT_ERR] = err;
        s[STAT_TXF] = txf;
        s[STAT_RXE] = rxe;
        return s;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_timeout_counter.sv
// Saturating wait counter; term_o flags the last permitted wait cycle (never when TIMEOUT_CYC=0).
module uart_mmio_ctrl_timeout_counter #(
    parameter int TIMEOUT_CYC = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign term_o = (TIMEOUT_CYC != 0) && (cnt_q == TERM);

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing MMIO decoder for the UART: turns level-held requests into single
// rd_uart/wr_uart strobes, with bounded blocking on the FIFO flags.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       rd_uart,
    output logic       wr_uart,
    output logic [7:0] w_data,
    input  logic [7:0] r_data,
    input  logic       tx_full,
    input  logic       rx_empty
);

    state_e state_q;
    logic   err_q;
    logic   tmo_term;

    uart_mmio_ctrl_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .en_i   ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)),
        .term_o (tmo_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            w_data    <= '0;
        end else begin
            cpu_ack <= 1'b0;
            rd_uart <= 1'b0;
            wr_uart <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        state_q <= ST_DONE;
                        cpu_ack <= 1'b1;
                        case (cpu_addr)
                            ADDR_DATA: begin
                                if (!cpu_we) begin
                                    if (!rx_empty) begin
                                        cpu_rdata <= r_data;
                                        rd_uart   <= 1'b1;
                                    end else begin
                                        cpu_ack <= 1'b0;
                                        state_q <= ST_RD_WAIT;
                                    end
                                end else begin
                                    if (!tx_full) begin
                                        w_data  <= cpu_wdata;
                                        wr_uart <= 1'b1;
                                    end else begin
                                        cpu_ack <= 1'b0;
                                        state_q <= ST_WR_WAIT;
                                    end
                                end
                            end
                            ADDR_STATUS: begin
                                if (!cpu_we) cpu_rdata <= status_byte(err_q, tx_full, rx_empty);
                            end
                            ADDR_CTRL: begin
                                if (!cpu_we)          cpu_rdata <= '0;
                                else if (cpu_wdata[0]) err_q    <= 1'b0;
                            end
                            default: begin
                                if (!cpu_we) cpu_rdata <= '0;
                            end
                        endcase
                    end
                end
                // A dropped request abandons the wait silently; data beats a coincident timeout.
                ST_RD_WAIT: begin
                    if (!cpu_req) begin
                        state_q <= ST_IDLE;
                    end else if (!rx_empty) begin
                        cpu_rdata <= r_data;
                        rd_uart   <= 1'b1;
                        cpu_ack   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (tmo_term) begin
                        cpu_rdata <= '0;
                        cpu_ack   <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_WR_WAIT: begin
                    if (!cpu_req) begin
                        state_q <= ST_IDLE;
                    end else if (!tx_full) begin
                        w_data  <= cpu_wdata;
                        wr_uart <= 1'b1;
                        cpu_ack <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tmo_term) begin
                        cpu_ack <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    if (!cpu_req) state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed scoreboard bench for uart_mmio_ctrl with TIMEOUT_CYC=16.
module tb_uart_mmio_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] r_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       rx_empty = 1'b1;

    always #5 clk = ~clk;

    uart_mmio_ctrl #(
        .TIMEOUT_CYC (16),
        .CNT_W       (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .rd_uart   (rd_uart),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .r_data    (r_data),
        .tx_full   (tx_full),
        .rx_empty  (rx_empty)
    );

    typedef struct {
        logic       chk_rdata;
        logic [7:0] rdata;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {7'b0, cpu_ack}, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_rdata) chk("ack_rdata", cpu_rdata, e.rdata);
                    chk("ack_rd_uart", {7'b0, rd_uart}, {7'b0, e.rd});
                    chk("ack_wr_uart", {7'b0, wr_uart}, {7'b0, e.wr});
                    if (e.wr) chk("ack_w_data", w_data, e.wdata);
                end
            end else if (rd_uart || wr_uart) begin
                chk("strobe_without_ack", {7'b0, rd_uart | wr_uart}, 8'h00);
            end
            if (rd_uart && wr_uart) chk("rd_and_wr_together", 8'h01, 8'h00);
            if (rd_uart) rd_cnt++;
            if (wr_uart) wr_cnt++;
        end
    end

    task automatic issue(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         input logic push, input logic chk_rd, input logic [7:0] rdata,
                         input logic rd, input logic wr);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.chk_rdata = chk_rd;
            e.rdata     = rdata;
            e.rd        = rd;
            e.wr        = wr;
            e.wdata     = wd;
            exp_q.push_back(e);
        end
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
    endtask

    task automatic wait_ack(input string name, input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = cpu_ack;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_no_ack: no ack after %0d cycles, expected ack", name, n);
        end else if (exp_lat > 0) begin
            chk({name, "_latency"}, 8'(n), 8'(exp_lat));
        end
    endtask

    task automatic drop_req();
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic access(input string name, input logic we, input logic [1:0] addr,
                          input logic [7:0] wd, input logic chk_rd, input logic [7:0] rdata,
                          input logic rd, input logic wr, input int lat);
        issue(we, addr, wd, 1'b1, chk_rd, rdata, rd, wr);
        wait_ack(name, lat);
        drop_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, w0;

        repeat (2) @(negedge clk);
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_ack", {7'b0, cpu_ack}, 8'h00);
        chk("reset_rd_uart", {7'b0, rd_uart}, 8'h00);
        chk("reset_wr_uart", {7'b0, wr_uart}, 8'h00);
        chk("reset_w_data", w_data, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        access("status0", 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);

        // Pop with the request held afterwards: only one rd_uart allowed.
        rx_empty = 1'b0;
        r_data   = 8'h41;
        r0 = rd_cnt;
        issue(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0);
        wait_ack("rd_data", 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rd_single_pulse", 8'(rd_cnt - r0), 8'd1);
        drop_req();
        rx_empty = 1'b1;

        // Write blocked on tx_full, released after 4 cycles.
        tx_full = 1'b1;
        issue(1'b1, 2'd0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                tx_full = 1'b0;
            end
        join_none
        wait_ack("wr_blocked", 5);
        drop_req();

        r0 = rd_cnt;
        access("rd_timeout", 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 17);
        chk("timeout_no_pop", 8'(rd_cnt - r0), 8'd0);
        access("status_err", 1'b0, 2'd1, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 1);
        access("ctrl_clr", 1'b1, 2'd2, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1);
        access("status_clr", 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);

        // Data appears exactly in the terminal wait cycle: data must win.
        issue(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        fork
            begin
                repeat (16) @(posedge clk);
                #1;
                r_data   = 8'h77;
                rx_empty = 1'b0;
            end
        join_none
        wait_ack("data_wins", 17);
        drop_req();
        rx_empty = 1'b1;
        access("status_no_err", 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);

        w0 = wr_cnt;
        access("wr_10", 1'b1, 2'd0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1);
        access("wr_11", 1'b1, 2'd0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1);
        access("wr_12", 1'b1, 2'd0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1);
        chk("wr_burst_count", 8'(wr_cnt - w0), 8'd3);

        // Abort: request withdrawn while waiting on an empty RX FIFO.
        a0 = ack_cnt;
        r0 = rd_cnt;
        issue(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        drop_req();
        repeat (3) @(negedge clk);
        chk("abort_no_ack", 8'(ack_cnt - a0), 8'd0);
        chk("abort_no_pop", 8'(rd_cnt - r0), 8'd0);
        access("status_abort", 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);

        access("rd_ctrl", 1'b0, 2'd2, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1);
        w0 = wr_cnt;
        access("wr_rsvd", 1'b1, 2'd3, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1);
        chk("wr_rsvd_no_push", 8'(wr_cnt - w0), 8'd0);
        rx_empty = 1'b0;
        r_data   = 8'hA5;
        access("rd_a5", 1'b0, 2'd0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1);
        rx_empty = 1'b1;
        access("rd_rsvd", 1'b0, 2'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1);
        rx_empty = 1'b0;
        access("rd_a5_again", 1'b0, 2'd0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1);
        rx_empty = 1'b1;

        // Asynchronous reset in the middle of RD_WAIT.
        a0 = ack_cnt;
        issue(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_rdata", cpu_rdata, 8'h00);
        chk("arst_w_data", w_data, 8'h00);
        chk("arst_ack", {7'b0, cpu_ack}, 8'h00);
        chk("arst_rd_uart", {7'b0, rd_uart}, 8'h00);
        chk("arst_wr_uart", {7'b0, wr_uart}, 8'h00);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_ack", 8'(ack_cnt - a0), 8'd0);
        access("status_after_rst", 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
